// File: rtl/rega_pkg.sv
// Shared state and source codes for the irrigation sequencing controller.
package rega_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_IRRIGATE = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    localparam logic SRC_TANK  = 1'b0;
    localparam logic SRC_MAINS = 1'b1;

endpackage

// File: rtl/rega_debounce.sv
// Two-flop synchronizer for the raw soil sensor followed by a consecutive-sample debouncer.
module rega_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic soil_dry_i,
    output logic dry_db_o
);

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]     sync_q;
    logic [DbW-1:0] cnt_q, cnt_d;
    logic           db_q, db_d;

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + DbW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], soil_dry_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign dry_db_o = db_q;

endmodule

// File: rtl/rega_irrigation_ctrl.sv
// Irrigation water-path sequencer: source selection with break-before-make settling,
// bounded run time, cooldown between runs and a sticky fault when no source is usable.
module rega_irrigation_ctrl
    import rega_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES   = 2,
    parameter int unsigned MAX_IRR_CYCLES  = 16,
    parameter int unsigned MIN_OFF_CYCLES  = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       soil_dry_i,
    input  logic       tank_low_i,
    input  logic       mains_ok_i,
    output logic       src_sel_o,
    output logic       valve_open_o,
    output logic       busy_o,
    output logic       fault_o,
    output logic       irr_timeout_o,
    output logic [2:0] state_o
);

    localparam int unsigned CntMax = (1 << CNT_W) - 1;

    if (DEBOUNCE_CYCLES < 1 || SETTLE_CYCLES < 1 || MAX_IRR_CYCLES < 2 ||
        MIN_OFF_CYCLES < 1 || SETTLE_CYCLES > CntMax || MAX_IRR_CYCLES > CntMax ||
        MIN_OFF_CYCLES > CntMax) begin : g_bad_param
        $error("rega_irrigation_ctrl: cycle parameter out of range for CNT_W");
    end

    logic dry_db;

    rega_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .soil_dry_i(soil_dry_i),
        .dry_db_o  (dry_db)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;   // settle / cooldown down-counter
    logic [CNT_W-1:0] run_q, run_d;   // open cycles used so far in this run
    logic             src_q, src_d;
    logic             tmo_d;
    logic             valve_q, busy_q, fault_q, tmo_q;
    logic             src_lost, alt_ok;

    assign src_lost = (src_q == SRC_TANK) ? tank_low_i : ~mains_ok_i;
    assign alt_ok   = (src_q == SRC_TANK) ? mains_ok_i : ~tank_low_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        src_d   = src_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && dry_db) begin
                    if (!tank_low_i) begin
                        src_d   = SRC_TANK;
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYCLES);
                        run_d   = '0;
                    end else if (mains_ok_i) begin
                        src_d   = SRC_MAINS;
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYCLES);
                        run_d   = '0;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_SETTLE: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IRRIGATE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_IRRIGATE: begin
                if (!enable_i) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = CNT_W'(MIN_OFF_CYCLES);
                end else if (src_lost) begin
                    if (alt_ok) begin
                        // Switching keeps the run budget: this open cycle still counts.
                        src_d   = ~src_q;
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYCLES);
                        run_d   = run_q + CNT_W'(1);
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else if (run_q >= CNT_W'(MAX_IRR_CYCLES - 1)) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = CNT_W'(MIN_OFF_CYCLES);
                    tmo_d   = 1'b1;
                end else if (!dry_db) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = CNT_W'(MIN_OFF_CYCLES);
                end else begin
                    run_d = run_q + CNT_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FAULT: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            run_q   <= '0;
            src_q   <= SRC_TANK;
            valve_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            src_q   <= src_d;
            valve_q <= (state_d == ST_IRRIGATE);
            busy_q  <= (state_d != ST_IDLE);
            fault_q <= (state_d == ST_FAULT);
            tmo_q   <= tmo_d;
        end
    end

    assign src_sel_o     = src_q;
    assign valve_open_o  = valve_q;
    assign busy_o        = busy_q;
    assign fault_o       = fault_q;
    assign irr_timeout_o = tmo_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_rega_irrigation_ctrl.sv
// Randomized + directed bench for rega_irrigation_ctrl with a cycle-level reference model.
module tb_rega_irrigation_ctrl;

    localparam int DEB  = 4;
    localparam int SET  = 2;
    localparam int MAXI = 16;
    localparam int OFF  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       soil_dry = 1'b0;
    logic       tank_low = 1'b0;
    logic       mains_ok = 1'b0;
    logic       src_sel, valve_open, busy, fault, irr_timeout;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    rega_irrigation_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SET),
        .MAX_IRR_CYCLES (MAXI),
        .MIN_OFF_CYCLES (OFF),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .soil_dry_i   (soil_dry),
        .tank_low_i   (tank_low),
        .mains_ok_i   (mains_ok),
        .src_sel_o    (src_sel),
        .valve_open_o (valve_open),
        .busy_o       (busy),
        .fault_o      (fault),
        .irr_timeout_o(irr_timeout),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       valve;
        logic       busy;
        logic       fault;
        logic       src;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: phase codes are the documented state numbers.
    localparam int PH_IDLE = 0, PH_SETTLE = 1, PH_IRR = 2, PH_COOL = 3, PH_FAULT = 4;
    int ph = PH_IDLE;
    int settle_left = 0, cool_left = 0, open_cnt = 0, streak = 0;
    bit msrc = 0, db = 0, r1 = 0, r2 = 0, pulse = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit   lost, alt;
        exp_t e;
        if (!rst_n) begin
            ph = PH_IDLE; settle_left = 0; cool_left = 0; open_cnt = 0; streak = 0;
            msrc = 0; db = 0; r1 = 0; r2 = 0; pulse = 0;
            exp_q.delete();
        end else begin
            pulse = 0;
            case (ph)
                PH_IDLE: if (enable && db) begin
                    if (!tank_low || mains_ok) begin
                        msrc = tank_low;
                        ph = PH_SETTLE; settle_left = SET; open_cnt = 0;
                    end else ph = PH_FAULT;
                end
                PH_SETTLE: if (!enable) ph = PH_IDLE;
                           else begin
                               settle_left--;
                               if (settle_left == 0) ph = PH_IRR;
                           end
                PH_IRR: begin
                    open_cnt++;
                    lost = msrc ? !mains_ok : tank_low;
                    alt  = msrc ? !tank_low : mains_ok;
                    if (!enable) begin ph = PH_COOL; cool_left = OFF; end
                    else if (lost) begin
                        if (alt) begin msrc = !msrc; ph = PH_SETTLE; settle_left = SET; end
                        else ph = PH_FAULT;
                    end
                    else if (open_cnt >= MAXI) begin ph = PH_COOL; cool_left = OFF; pulse = 1; end
                    else if (!db) begin ph = PH_COOL; cool_left = OFF; end
                end
                PH_COOL: begin
                    cool_left--;
                    if (cool_left == 0) ph = PH_IDLE;
                end
                PH_FAULT: if (!enable) ph = PH_IDLE;
                default: ph = PH_IDLE;
            endcase
            // Debounced level follows the sample taken two edges ago.
            if (r2 != db) begin
                streak++;
                if (streak == DEB) begin db = !db; streak = 0; end
            end else streak = 0;
            r2 = r1;
            r1 = soil_dry;
            e.st = 3'(ph); e.valve = (ph == PH_IRR); e.busy = (ph != PH_IDLE);
            e.fault = (ph == PH_FAULT); e.src = msrc; e.tmo = pulse;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares every cycle away from the rising edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t act;
        act = {state, valve_open, busy, fault, src_sel, irr_timeout};
        if (!rst_n) begin
            checks++;
            if (act !== '0) begin
                errors++;
                $display("FAIL reset_outputs t=%0t act=%b req=%b", $time, act, 8'b0);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle t=%0t act st=%0d v=%b b=%b f=%b s=%b t=%b req st=%0d v=%b b=%b f=%b s=%b t=%b",
                         $time, act.st, act.valve, act.busy, act.fault, act.src, act.tmo,
                         e.st, e.valve, e.busy, e.fault, e.src, e.tmo);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s t=%0t act=%0d req=%0d", name, $time, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valve(input int limit, input string name);
        int n = 0;
        while (valve_open !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (valve_open !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s t=%0t act=timeout req=valve_open", name, $time);
        end
    endtask

    initial begin : stim
        int cnt;
        bit any_open;
        step(3);
        #1 rst_n = 1'b1;
        enable = 1'b1; mains_ok = 1'b1;
        step(2);

        // Normal run from tank, ended by the soil turning wet.
        soil_dry = 1'b1;
        wait_valve(20, "t1_valve");
        check("t1_src_tank", src_sel, 0);
        step(4);
        soil_dry = 1'b0;
        step(30);
        check("t1_idle", state, 0);

        // Held dry: run is cut by the timeout.
        soil_dry = 1'b1;
        wait_valve(20, "t2_valve");
        cnt = 0;
        while (valve_open === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("t2_open_len", cnt, MAXI);
        check("t2_timeout_pulse", irr_timeout, 1);
        step(1);
        check("t2_pulse_once", irr_timeout, 0);
        step(30);
        soil_dry = 1'b0;
        step(40);

        // Tank runs dry mid-run: break-before-make switch to mains.
        soil_dry = 1'b1;
        wait_valve(40, "t3_valve");
        step(3);
        tank_low = 1'b1;
        step(1);
        check("t3_valve_closed", valve_open, 0);
        check("t3_src_mains", src_sel, 1);
        step(30);
        soil_dry = 1'b0; tank_low = 1'b0;
        step(40);

        // No usable source: fault, cleared by an enable pulse.
        tank_low = 1'b1; mains_ok = 1'b0; soil_dry = 1'b1;
        step(15);
        check("t4_fault", fault, 1);
        check("t4_valve", valve_open, 0);
        enable = 1'b0;
        step(1);
        check("t4_cleared_state", state, 0);
        check("t4_cleared_fault", fault, 0);
        enable = 1'b1; soil_dry = 1'b0; tank_low = 1'b0; mains_ok = 1'b1;
        step(40);

        // Glitchy sensor never reaches the debounce threshold.
        any_open = 0;
        for (int r = 0; r < 10; r++) begin
            soil_dry = 1'b1;
            for (int k = 0; k < 3; k++) begin @(negedge clk); any_open |= valve_open; end
            soil_dry = 1'b0;
            @(negedge clk); any_open |= valve_open;
        end
        check("t5_no_open", any_open, 0);
        step(10);

        // Asynchronous reset between edges mid-run, on the mains source.
        tank_low = 1'b1; mains_ok = 1'b1; soil_dry = 1'b1;
        wait_valve(40, "t6_valve");
        step(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valve_now", valve_open, 0);
        check("t6_busy_now", busy, 0);
        check("t6_src_now", src_sel, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1);
        check("t6_state_after", state, 0);
        soil_dry = 1'b0; tank_low = 1'b0;
        step(30);

        // Randomized segments.
        for (int s = 0; s < 200; s++) begin
            enable   = ($urandom_range(0, 19) != 0);
            soil_dry = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tank_low = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) mains_ok = 1'($urandom_range(0, 1));
            step($urandom_range(1, 25));
        end
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
